serial_cmp_arbiter: RTL and testbench

- Shares one MSB-first serial magnitude-compare engine among NREQ requesters.
- Round-robin arbitration, operand capture and bit-serial sequencing, one W-bit compare at a time.
- Returns a one-cycle result pulse tagged with the requester id.
- Sits between requester blocks and the serial comparison datapath in the comparator subsystem.

---
 rtl/serial_cmp_arbiter_pkg.sv | 19 +
 rtl/serial_cmp_arbiter_if.sv | 29 ++
 rtl/serial_cmp_engine.sv | 75 +++++++
 rtl/serial_cmp_arbiter.sv | 117 +++++++++++
 tb/tb_serial_cmp_arbiter.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_cmp_arbiter_pkg.sv
// Shared state/result encodings and helpers for the serial compare arbiter.
package serial_cmp_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Result word is {lt, eq, gt}, exactly one bit set.
    localparam logic [2:0] RES_LT = 3'b100;
    localparam logic [2:0] RES_EQ = 3'b010;
    localparam logic [2:0] RES_GT = 3'b001;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_cmp_arbiter_if.sv
// Requester-side bundle: level requests, packed operands, ack and tagged result.
interface serial_cmp_arbiter_if #(
    parameter int NREQ = 4,
    parameter int W    = 4
);
    localparam int IDW = serial_cmp_arbiter_pkg::id_width(NREQ);

    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] a_in;
    logic [NREQ*W-1:0] b_in;
    logic [NREQ-1:0]   ack;
    logic              busy;
    logic              rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic              less_than;
    logic              equal_to;
    logic              greater_than;

    modport master (
        output req, a_in, b_in,
        input  ack, busy, rsp_valid, rsp_id, less_than, equal_to, greater_than
    );

    modport slave (
        input  req, a_in, b_in,
        output ack, busy, rsp_valid, rsp_id, less_than, equal_to, greater_than
    );

endinterface

// File: rtl/serial_cmp_engine.sv
// MSB-first bit-serial magnitude compare; SERIAL_CMP_EARLY_EXIT_EN ends on the first differing bit.
module serial_cmp_engine
    import serial_cmp_arbiter_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         shift_en,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         done,
    output logic [2:0]   result
);
    localparam int CW = $clog2(W + 1);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    logic [W-1:0]  sa;
    logic [W-1:0]  sb;
    logic [CW-1:0] cnt;
    logic          found;
    logic          gt_q;
    logic          lt_q;
    logic          diff_now;
    logic          cur_gt;
    logic          cur_lt;

    // Result includes the bit being examined this cycle so done and result line up.
    always_comb begin
        diff_now = !found && (sa[W-1] != sb[W-1]);
        cur_gt   = found ? gt_q : (diff_now && sa[W-1]);
        cur_lt   = found ? lt_q : (diff_now && sb[W-1]);
        done     = shift_en && ((cnt == CW'(1)) || (EARLY_EXIT && diff_now));
        if (cur_lt) begin
            result = RES_LT;
        end else if (cur_gt) begin
            result = RES_GT;
        end else begin
            result = RES_EQ;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sa    <= '0;
            sb    <= '0;
            cnt   <= '0;
            found <= 1'b0;
            gt_q  <= 1'b0;
            lt_q  <= 1'b0;
        end else if (load) begin
            sa    <= a;
            sb    <= b;
            cnt   <= CW'(W);
            found <= 1'b0;
            gt_q  <= 1'b0;
            lt_q  <= 1'b0;
        end else if (shift_en && (cnt != '0)) begin
            sa  <= sa << 1;
            sb  <= sb << 1;
            cnt <= cnt - 1'b1;
            if (diff_now) begin
                found <= 1'b1;
                gt_q  <= sa[W-1];
                lt_q  <= sb[W-1];
            end
        end
    end

endmodule

// File: rtl/serial_cmp_arbiter.sv
// Round-robin arbiter sharing one serial compare engine among NREQ requesters.
// Early-exit timing is selected by SERIAL_CMP_EARLY_EXIT_EN inside the engine.
//
// state    | meaning
// ST_IDLE  | waiting for any req; grants, captures operands, pulses ack
// ST_SHIFT | engine compares one bit per cycle
// ST_DONE  | rsp_valid high with tagged flags; pointer advances past winner
module serial_cmp_arbiter
    import serial_cmp_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = 4
) (
    input logic                 clk,
    input logic                 reset,
    serial_cmp_arbiter_if.slave bus
);
    localparam int IDW = id_width(NREQ);

    state_t          state;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  winner;
    logic [IDW-1:0]  grant_id;
    logic [IDW-1:0]  idx;
    logic            grant_any;
    logic [NREQ-1:0] grant_oh;
    logic [W-1:0]    a_sel;
    logic [W-1:0]    b_sel;
    logic            eng_load;
    logic            eng_shift;
    logic            eng_done;
    logic [2:0]      eng_res;

    // Scan from the farthest offset down so the nearest set request at/after ptr wins.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        idx       = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = IDW'((int'(ptr) + k) % NREQ);
            if (bus.req[idx]) begin
                grant_any = 1'b1;
                grant_id  = idx;
            end
        end
        grant_oh           = '0;
        grant_oh[grant_id] = 1'b1;
        a_sel              = bus.a_in[grant_id*W +: W];
        b_sel              = bus.b_in[grant_id*W +: W];
    end

    assign eng_load  = (state == ST_IDLE) && grant_any;
    assign eng_shift = (state == ST_SHIFT);

    serial_cmp_engine #(.W(W)) u_engine (
        .clk      (clk),
        .reset    (reset),
        .load     (eng_load),
        .shift_en (eng_shift),
        .a        (a_sel),
        .b        (b_sel),
        .done     (eng_done),
        .result   (eng_res)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= ST_IDLE;
            ptr              <= '0;
            winner           <= '0;
            bus.ack          <= '0;
            bus.busy         <= 1'b0;
            bus.rsp_valid    <= 1'b0;
            bus.rsp_id       <= '0;
            bus.less_than    <= 1'b0;
            bus.equal_to     <= 1'b0;
            bus.greater_than <= 1'b0;
        end else begin
            bus.ack       <= '0;
            bus.rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_any) begin
                        winner   <= grant_id;
                        bus.ack  <= grant_oh;
                        bus.busy <= 1'b1;
                        state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (eng_done) begin
                        bus.rsp_valid    <= 1'b1;
                        bus.rsp_id       <= winner;
                        bus.less_than    <= eng_res[2];
                        bus.equal_to     <= eng_res[1];
                        bus.greater_than <= eng_res[0];
                        state            <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (winner == IDW'(NREQ - 1)) begin
                        ptr <= '0;
                    end else begin
                        ptr <= winner + 1'b1;
                    end
                    bus.busy <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_cmp_arbiter.sv
// Self-checking bench: directed and randomized requests against a queue-based reference model.
module tb_serial_cmp_arbiter;
    localparam int NREQ = 4;
    localparam int W    = 4;

    typedef struct {
        int         id;
        logic [2:0] res;
        int         due;
    } exp_t;

    logic clk;
    logic reset;

    serial_cmp_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

    serial_cmp_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_tests;
    int         n_fail;
    int         cyc;
    int         ptr_m;
    int         prev_ack;
    int         prev_lat;
    bit         chain;
    bit         rst_last;
    logic [3:0] cur_req;
    logic [3:0] req_last;
    exp_t       exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; also police the requester rule that req stays high until acked.
    task automatic tick();
        logic [3:0] r_now;
        logic [3:0] a_now;
        r_now = bus.req;
        a_now = bus.ack;
        if (!reset && !rst_last) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_last[i] && !r_now[i]) begin
                    n_tests++;
                    assert (a_now[i] === 1'b1) else begin
                        n_fail++;
                        $error("FAIL req_drop_before_ack id=%0d observed_ack=%0b expected_ack=1", i, a_now[i]);
                    end
                end
            end
        end
        req_last = r_now;
        rst_last = reset;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic int rr_pick(input logic [3:0] m, input int p);
        logic [3:0] t;
        for (int k = 0; k < NREQ; k++) begin
            t = m >> ((p + k) % NREQ);
            if (t[0]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [2:0] cmp_ref(input logic [W-1:0] a, input logic [W-1:0] b);
        if (a < b) return 3'b100;
        if (a == b) return 3'b010;
        return 3'b001;
    endfunction

    function automatic int lat_ref(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        for (int j = 0; j < W; j++) begin
            if (a[W-1-j] != b[W-1-j]) return j + 1;
        end
`endif
        return W;
    endfunction

    task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.a_in[i*W +: W] = a;
        bus.b_in[i*W +: W] = b;
    endtask

    task automatic rand_ops(input int i);
        logic [W-1:0] a;
        logic [W-1:0] b;
        a = W'($urandom);
        b = ($urandom_range(3, 0) == 0) ? a : W'($urandom);
        set_ops(i, a, b);
    endtask

    // Run until n_acks grants have been seen and every response has arrived.
    task automatic run(input int n_acks, input logic [3:0] hold);
        int         got;
        int         budget;
        int         w;
        int         lat;
        exp_t       e;
        logic [W-1:0] av;
        logic [W-1:0] bv;
        got    = 0;
        budget = 0;
        while ((got < n_acks || exp_q.size() > 0) && budget < 300) begin
            tick();
            budget++;
            if (bus.rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_cycle", 32'(cyc), 32'(e.due));
                    check("rsp_id", 32'(bus.rsp_id), 32'(e.id));
                    check("rsp_flags", 32'({bus.less_than, bus.equal_to, bus.greater_than}), 32'(e.res));
                    check("busy_at_rsp", 32'(bus.busy), 32'd1);
                end
            end
            if (bus.ack != '0) begin
                w = rr_pick(cur_req, ptr_m);
                if (w < 0) begin
                    check("ack_spurious", 32'(bus.ack), 32'd0);
                end else begin
                    check("ack_onehot", 32'(bus.ack), 32'(4'b0001 << w));
                    check("busy_at_ack", 32'(bus.busy), 32'd1);
                    if (prev_ack >= 0 && chain)
                        check("ack_spacing", 32'(cyc - prev_ack), 32'(prev_lat + 2));
                    av = bus.a_in[w*W +: W];
                    bv = bus.b_in[w*W +: W];
                    lat = lat_ref(av, bv);
                    e.id  = w;
                    e.res = cmp_ref(av, bv);
                    e.due = cyc + lat;
                    exp_q.push_back(e);
                    prev_ack = cyc;
                    prev_lat = lat;
                    ptr_m    = (w + 1) % NREQ;
                    got++;
                    if (hold[w]) rand_ops(w);
                    else cur_req[w] = 1'b0;
                    chain   = (cur_req != '0);
                    bus.req = cur_req;
                end
            end
        end
        check("acks_granted", 32'(got), 32'(n_acks));
        check("rsp_outstanding", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic one_req(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
        set_ops(id, a, b);
        cur_req  = 4'b0001 << id;
        bus.req  = cur_req;
        prev_ack = -1;
        run(1, 4'b0000);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        cur_req = '0;
        bus.req = '0;
        tick();
        tick();
        reset    = 1'b0;
        ptr_m    = 0;
        prev_ack = -1;
        exp_q.delete();
        tick();
    endtask

    initial begin
        int         bud;
        int         rsp_seen;
        logic [3:0] mask;
        n_tests  = 0;
        n_fail   = 0;
        cyc      = 0;
        ptr_m    = 0;
        prev_ack = -1;
        prev_lat = 0;
        chain    = 1'b0;
        rst_last = 1'b1;
        req_last = '0;
        cur_req  = '0;
        reset    = 1'b1;
        bus.req  = '0;
        bus.a_in = '0;
        bus.b_in = '0;
        repeat (3) tick();

        check("reset_ack", 32'(bus.ack), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset_rsp_id", 32'(bus.rsp_id), 32'd0);
        check("reset_flags", 32'({bus.less_than, bus.equal_to, bus.greater_than}), 32'd0);
        reset = 1'b0;
        tick();

        one_req(0, 4'b1010, 4'b1001);
        one_req(0, 4'hF, 4'hF);
        tick();
        check("flags_hold", 32'({bus.less_than, bus.equal_to, bus.greater_than}), 32'b010);
        check("rsp_one_cycle", 32'(bus.rsp_valid), 32'd0);
        one_req(0, 4'b0000, 4'b0001);
        one_req(0, 4'b0111, 4'b1000);
        one_req(0, 4'b1101, 4'b1100);
        one_req(2, 4'b0011, 4'b0110);

        // Round robin with all four held, then 1,2 released leaving 1001 with ptr=1.
        do_reset();
        for (int i = 0; i < NREQ; i++) rand_ops(i);
        cur_req  = 4'b1111;
        bus.req  = cur_req;
        prev_ack = -1;
        run(5, 4'b1001);
        check("rr_ptr_model", 32'(ptr_m), 32'd1);
        run(2, 4'b0000);

        // Reset during the second SHIFT cycle drops the compare in flight.
        do_reset();
        set_ops(0, 4'b1100, 4'b0011);
        cur_req = 4'b0001;
        bus.req = cur_req;
        bud = 0;
        do begin
            tick();
            bud++;
        end while (bus.ack == '0 && bud < 20);
        check("rst_test_ack", 32'(bus.ack), 32'b0001);
        cur_req = '0;
        bus.req = '0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("midrst_ack", 32'(bus.ack), 32'd0);
        check("midrst_flags", 32'({bus.less_than, bus.equal_to, bus.greater_than}), 32'd0);
        rsp_seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.rsp_valid) rsp_seen++;
        end
        check("midrst_no_rsp", 32'(rsp_seen), 32'd0);
        ptr_m    = 0;
        prev_ack = -1;
        exp_q.delete();
        set_ops(2, 4'b0101, 4'b0101);
        set_ops(3, 4'b1001, 4'b0001);
        cur_req = 4'b1100;
        bus.req = cur_req;
        run(2, 4'b0000);

        // Randomized request masks and operands.
        for (int r = 0; r < 30; r++) begin
            mask = 4'($urandom_range(15, 1));
            for (int i = 0; i < NREQ; i++) rand_ops(i);
            cur_req  = mask;
            bus.req  = cur_req;
            prev_ack = -1;
            run($countones(mask), 4'b0000);
            if ($urandom_range(1, 0) == 1) tick();
        end

        tick();
        tick();
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_ack", 32'(bus.ack), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
